// File: rtl/fetch_pkg.sv
// Shared types and defaults for the PC/nPC fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    StBoot  = 2'b00,
    StRun   = 2'b01,
    StStall = 2'b10
  } fetch_state_e;

  localparam int unsigned DefAddrW      = 8;
  localparam int unsigned DefResetPc    = 0;
  localparam int unsigned DefInstrBytes = 4;

  localparam logic [31:0] Nop = 32'b0;

endpackage

// File: rtl/fetch_pc_unit_pc_reg.sv
// Enabled address register with asynchronous active-low reset to a fixed value.
module pc_reg #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             LE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      Q <= RST_VAL;
    end else if (LE) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC/nPC fetch sequencer: delayed branch, stall, annul, boot cycle and
// misaligned-target detection.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned RESET_PC    = DefResetPc,
  parameter int unsigned INSTR_BYTES = DefInstrBytes  // must be a power of two
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              LE,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  input  logic              annul,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] nPC,
  output logic              fetch_valid,
  output logic              if_id_nop,
  output logic              align_err
);

  localparam logic [ADDR_W-1:0] Incr    = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] RstPc   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] RstNpc  = ADDR_W'(RESET_PC + INSTR_BYTES);

  fetch_state_e      state_q, state_d;
  logic              adv;
  logic [ADDR_W-1:0] npc_next;
  logic              misaligned;
  logic              align_err_q;

  // State register
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; LE is deliberately ignored while booting
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (!LE) state_d = StStall;
      StStall: if (LE) state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    fetch_valid = (state_q != StBoot);
    if_id_nop   = annul & LE & fetch_valid;
  end

  // Leaving STALL on LE=1 advances on that same edge, just like RUN.
  assign adv        = LE & fetch_valid;
  assign misaligned = |(target & OffMask);
  assign npc_next   = redirect ? (target & ~OffMask) : (nPC + Incr);

  pc_reg #(
    .WIDTH  (ADDR_W),
    .RST_VAL(RstPc)
  ) u_pc_reg (
    .Clk(Clk),
    .R  (R),
    .LE (adv),
    .D  (nPC),
    .Q  (PC)
  );

  pc_reg #(
    .WIDTH  (ADDR_W),
    .RST_VAL(RstNpc)
  ) u_npc_reg (
    .Clk(Clk),
    .R  (R),
    .LE (adv),
    .D  (npc_next),
    .Q  (nPC)
  );

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= adv & redirect & misaligned;
    end
  end

  assign align_err = align_err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit at default parameters (8-bit, step 4).
module tb_fetch_pc_unit;

  logic       Clk = 1'b0;
  logic       R;
  logic       LE;
  logic       redirect;
  logic [7:0] target;
  logic       annul;
  logic [7:0] PC;
  logic [7:0] nPC;
  logic       fetch_valid;
  logic       if_id_nop;
  logic       align_err;

  fetch_pc_unit dut (
    .Clk        (Clk),
    .R          (R),
    .LE         (LE),
    .redirect   (redirect),
    .target     (target),
    .annul      (annul),
    .PC         (PC),
    .nPC        (nPC),
    .fetch_valid(fetch_valid),
    .if_id_nop  (if_id_nop),
    .align_err  (align_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       le;
    logic       redir;
    logic [7:0] tgt;
    logic       annul;
    logic       exp_nop;    // combinational, before the edge
    logic [7:0] exp_pc;     // registered, after the edge
    logic [7:0] exp_npc;
    logic       exp_valid;
    logic       exp_aerr;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] pc;
    logic [7:0] npc;
    logic       valid;
    logic       aerr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[28];
  vec_t rst_vecs[3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    LE       = v.le;
    redirect = v.redir;
    target   = v.tgt;
    annul    = v.annul;
    #1;
    check($sformatf("if_id_nop[%0d]", idx), {31'b0, if_id_nop}, {31'b0, v.exp_nop});
    sb.push_back('{idx: idx, pc: v.exp_pc, npc: v.exp_npc, valid: v.exp_valid,
                   aerr: v.exp_aerr});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check($sformatf("PC[%0d]", e.idx), {24'b0, PC}, {24'b0, e.pc});
    check($sformatf("nPC[%0d]", e.idx), {24'b0, nPC}, {24'b0, e.npc});
    check($sformatf("fetch_valid[%0d]", e.idx), {31'b0, fetch_valid}, {31'b0, e.valid});
    check($sformatf("align_err[%0d]", e.idx), {31'b0, align_err}, {31'b0, e.aerr});
  endtask

  initial begin
    //           le redir tgt    annul nop  pc     npc    valid aerr
    vecs[0]  = '{1, 0, 8'h00, 1, 0, 8'h00, 8'h04, 1, 0};  // boot edge, annul gated off
    vecs[1]  = '{1, 0, 8'h00, 0, 0, 8'h04, 8'h08, 1, 0};
    vecs[2]  = '{1, 0, 8'h00, 0, 0, 8'h08, 8'h0C, 1, 0};
    vecs[3]  = '{0, 1, 8'h80, 0, 0, 8'h08, 8'h0C, 1, 0};  // stall ignores redirect
    vecs[4]  = '{0, 1, 8'h80, 1, 0, 8'h08, 8'h0C, 1, 0};  // and annul
    vecs[5]  = '{0, 1, 8'h80, 0, 0, 8'h08, 8'h0C, 1, 0};
    vecs[6]  = '{1, 0, 8'h00, 0, 0, 8'h0C, 8'h10, 1, 0};
    vecs[7]  = '{1, 0, 8'h00, 0, 0, 8'h10, 8'h14, 1, 0};
    vecs[8]  = '{1, 1, 8'h40, 0, 0, 8'h14, 8'h40, 1, 0};  // taken branch, delay slot 0x14
    vecs[9]  = '{1, 0, 8'h00, 0, 0, 8'h40, 8'h44, 1, 0};
    vecs[10] = '{1, 0, 8'h00, 0, 0, 8'h44, 8'h48, 1, 0};
    vecs[11] = '{1, 1, 8'h1C, 0, 0, 8'h48, 8'h1C, 1, 0};
    vecs[12] = '{1, 0, 8'h00, 0, 0, 8'h1C, 8'h20, 1, 0};
    vecs[13] = '{1, 0, 8'h00, 0, 0, 8'h20, 8'h24, 1, 0};
    vecs[14] = '{1, 0, 8'h00, 1, 1, 8'h24, 8'h28, 1, 0};  // annul, untaken
    vecs[15] = '{1, 0, 8'h00, 0, 0, 8'h28, 8'h2C, 1, 0};
    vecs[16] = '{1, 1, 8'h60, 1, 1, 8'h2C, 8'h60, 1, 0};  // ba,a
    vecs[17] = '{1, 0, 8'h00, 0, 0, 8'h60, 8'h64, 1, 0};
    vecs[18] = '{1, 1, 8'h42, 0, 0, 8'h64, 8'h40, 1, 1};  // misaligned target
    vecs[19] = '{1, 0, 8'h00, 0, 0, 8'h40, 8'h44, 1, 0};
    vecs[20] = '{0, 1, 8'h43, 0, 0, 8'h40, 8'h44, 1, 0};  // misaligned but stalled
    vecs[21] = '{1, 0, 8'h00, 0, 0, 8'h44, 8'h48, 1, 0};
    vecs[22] = '{1, 1, 8'hF4, 0, 0, 8'h48, 8'hF4, 1, 0};
    vecs[23] = '{1, 0, 8'h00, 0, 0, 8'hF4, 8'hF8, 1, 0};
    vecs[24] = '{1, 0, 8'h00, 0, 0, 8'hF8, 8'hFC, 1, 0};
    vecs[25] = '{1, 0, 8'h00, 0, 0, 8'hFC, 8'h00, 1, 0};  // nPC wraps
    vecs[26] = '{1, 0, 8'h00, 0, 0, 8'h00, 8'h04, 1, 0};
    vecs[27] = '{1, 0, 8'h00, 0, 0, 8'h04, 8'h08, 1, 0};

    rst_vecs[0] = '{1, 0, 8'h00, 1, 0, 8'h00, 8'h04, 1, 0};
    rst_vecs[1] = '{1, 0, 8'h00, 0, 0, 8'h04, 8'h08, 1, 0};
    rst_vecs[2] = '{1, 0, 8'h00, 0, 0, 8'h08, 8'h0C, 1, 0};

    R        = 1'b0;
    LE       = 1'b1;
    redirect = 1'b0;
    target   = 8'h00;
    annul    = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_PC", {24'b0, PC}, 32'h00);
    check("rst_nPC", {24'b0, nPC}, 32'h04);
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_if_id_nop", {31'b0, if_id_nop}, 32'h0);
    check("rst_align_err", {31'b0, align_err}, 32'h0);

    @(negedge Clk);
    R     = 1'b1;
    annul = 1'b0;
    #1;
    check("boot_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    for (int i = 0; i < 28; i++) apply(vecs[i], i);

    // Asynchronous reset between edges while a redirect to 0x80 is pending
    LE       = 1'b1;
    redirect = 1'b1;
    target   = 8'h80;
    #2;
    R = 1'b0;
    #1;
    check("async_PC", {24'b0, PC}, 32'h00);
    check("async_nPC", {24'b0, nPC}, 32'h04);
    check("async_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    @(posedge Clk);
    #1;
    check("held_rst_nPC", {24'b0, nPC}, 32'h04);
    redirect = 1'b0;
    target   = 8'h00;
    @(negedge Clk);
    R = 1'b1;
    for (int i = 0; i < 3; i++) apply(rst_vecs[i], 100 + i);

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
